// File: rtl/pc_stack_unit.sv
// Program counter plus hardware return-address stack, driven by the
// active-low strobes from the sequence controller.
module pc_stack_unit #(
    parameter int DataWidth  = 16,
    parameter int StackDepth = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 PC_Rst,
    input  logic                 PC_Inc,
    input  logic                 PC_Ld,
    input  logic [1:0]           PC_Src,
    input  logic                 BRA_Src,
    input  logic                 STK_Ld,
    input  logic                 STK_Pop,
    input  logic [DataWidth-1:0] IR,
    input  logic [DataWidth-1:0] Src1,
    output logic [DataWidth-1:0] PC_Out,
    output logic [DataWidth-1:0] StkTop,
    output logic                 Stk_Empty,
    output logic                 Stk_Full,
    output logic                 Stk_Err
);
    localparam int AW  = $clog2(StackDepth);
    localparam int SPW = AW + 1;
    localparam logic [SPW-1:0] DEPTH = SPW'(StackDepth);

    logic [DataWidth-1:0] r_pc;
    logic [DataWidth-1:0] r_stk [StackDepth];
    logic [SPW-1:0]       r_sp;
    logic                 r_empty, r_full, r_err;

    logic [DataWidth-1:0] w_off, w_bra, w_tgt, w_top;
    logic [AW-1:0]        w_topidx, w_widx;
    logic [SPW-1:0]       w_sp_nxt;
    logic                 w_empty, w_full, w_we, w_err_set;
    logic                 w_unused;

    // Only IR[9:0] carries the branch offset.
    assign w_unused = ^IR[DataWidth-1:10];

    assign w_empty  = (r_sp == '0);
    assign w_full   = (r_sp == DEPTH);
    assign w_topidx = r_sp[AW-1:0] - AW'(1);
    assign w_top    = w_empty ? '0 : r_stk[w_topidx];

    assign w_off = {{(DataWidth-10){IR[9]}}, IR[9:0]};
    assign w_bra = r_pc + w_off;

    always_comb begin
        w_tgt = r_pc;
        case (PC_Src)
            2'b00:   w_tgt = BRA_Src ? w_bra : Src1;
            2'b01:   w_tgt = w_top;
            2'b10:   w_tgt = Src1;
            default: w_tgt = r_pc;
        endcase
    end

    // Push/pop decode; a simultaneous push+pop overwrites the top in place.
    always_comb begin
        w_sp_nxt  = r_sp;
        w_we      = 1'b0;
        w_widx    = r_sp[AW-1:0];
        w_err_set = 1'b0;
        case ({STK_Ld, STK_Pop})
            2'b01: begin
                if (w_full) w_err_set = 1'b1;
                else begin
                    w_we     = 1'b1;
                    w_sp_nxt = r_sp + SPW'(1);
                end
            end
            2'b10: begin
                if (w_empty) w_err_set = 1'b1;
                else w_sp_nxt = r_sp - SPW'(1);
            end
            2'b00: begin
                if (w_empty) w_err_set = 1'b1;
                else begin
                    w_we   = 1'b1;
                    w_widx = w_topidx;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_pc    <= '0;
            r_sp    <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (!PC_Rst)      r_pc <= '0;
            else if (!PC_Ld)  r_pc <= w_tgt;
            else if (!PC_Inc) r_pc <= r_pc + DataWidth'(1);
            r_sp    <= w_sp_nxt;
            r_empty <= (w_sp_nxt == '0);
            r_full  <= (w_sp_nxt == DEPTH);
            if (w_err_set) r_err <= 1'b1;
        end
    end

    // Stack contents are not reset; SP alone defines validity.
    always_ff @(posedge Clk) begin
        if (Reset && w_we) r_stk[w_widx] <= r_pc;
    end

    assign PC_Out    = r_pc;
    assign StkTop    = w_top;
    assign Stk_Empty = r_empty;
    assign Stk_Full  = r_full;
    assign Stk_Err   = r_err;
endmodule

// File: tb/tb_pc_stack_unit.sv
// Vector-table bench for pc_stack_unit with a queue scoreboard.
module tb_pc_stack_unit;
    logic        Clk = 1'b0;
    logic        Reset, PC_Rst, PC_Inc, PC_Ld, BRA_Src, STK_Ld, STK_Pop;
    logic [1:0]  PC_Src;
    logic [15:0] IR, Src1, PC_Out, StkTop;
    logic        Stk_Empty, Stk_Full, Stk_Err;

    pc_stack_unit #(.DataWidth(16), .StackDepth(4)) dut (
        .Clk(Clk), .Reset(Reset), .PC_Rst(PC_Rst), .PC_Inc(PC_Inc),
        .PC_Ld(PC_Ld), .PC_Src(PC_Src), .BRA_Src(BRA_Src), .STK_Ld(STK_Ld),
        .STK_Pop(STK_Pop), .IR(IR), .Src1(Src1), .PC_Out(PC_Out),
        .StkTop(StkTop), .Stk_Empty(Stk_Empty), .Stk_Full(Stk_Full),
        .Stk_Err(Stk_Err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst, prst, inc, ld;
        logic [1:0]  src;
        logic        bra, push, pop;
        logic [15:0] ir, src1;
        logic [15:0] pc, top;
        logic        emp, full, err;
    } vec_t;

    typedef struct {
        int          idx;
        logic [15:0] pc, top;
        logic        emp, full, err;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    function automatic vec_t v(logic rst, logic prst, logic inc, logic ld,
                               logic [1:0] src, logic bra, logic push, logic pop,
                               logic [15:0] ir, logic [15:0] src1,
                               logic [15:0] pc, logic [15:0] top,
                               logic emp, logic full, logic err);
        vec_t r;
        r.rst = rst; r.prst = prst; r.inc = inc; r.ld = ld; r.src = src;
        r.bra = bra; r.push = push; r.pop = pop; r.ir = ir; r.src1 = src1;
        r.pc = pc; r.top = top; r.emp = emp; r.full = full; r.err = err;
        return r;
    endfunction

    task automatic chk(string name, int idx, logic [15:0] act, logic [15:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, req);
        end
    endtask

    // Drive one vector before the edge, queue its expectation, compare after the edge.
    task automatic step(vec_t t, int idx);
        exp_t e, g;
        @(negedge Clk);
        Reset = t.rst; PC_Rst = t.prst; PC_Inc = t.inc; PC_Ld = t.ld;
        PC_Src = t.src; BRA_Src = t.bra; STK_Ld = t.push; STK_Pop = t.pop;
        IR = t.ir; Src1 = t.src1;
        e.idx = idx; e.pc = t.pc; e.top = t.top;
        e.emp = t.emp; e.full = t.full; e.err = t.err;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        if (sb.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL scoreboard vec %0d: got empty queue expected entry", idx);
        end else begin
            g = sb.pop_front();
            chk("pc",    g.idx, PC_Out,           g.pc);
            chk("top",   g.idx, StkTop,           g.top);
            chk("empty", g.idx, {15'd0, Stk_Empty}, {15'd0, g.emp});
            chk("full",  g.idx, {15'd0, Stk_Full},  {15'd0, g.full});
            chk("err",   g.idx, {15'd0, Stk_Err},   {15'd0, g.err});
        end
    endtask

    initial begin
        logic [15:0] pc_m;
        Reset = 1'b0; PC_Rst = 1'b1; PC_Inc = 1'b1; PC_Ld = 1'b1;
        PC_Src = 2'b11; BRA_Src = 1'b0; STK_Ld = 1'b1; STK_Pop = 1'b1;
        IR = '0; Src1 = '0;

        //            rst prst inc ld src  bra psh pop ir       src1     pc       top      e  f  err
        // reset, then PC_Inc three cycles
        tbl.push_back(v(0, 1, 1, 1, 2'b11, 0, 1, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 2'b10, 0, 0, 1, 16'h0000, 16'h0099, 16'h0000, 16'h0000, 1, 0, 0));
        tbl.push_back(v(1, 1, 0, 1, 2'b11, 0, 1, 1, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 1, 0, 0));
        tbl.push_back(v(1, 1, 0, 1, 2'b11, 0, 1, 1, 16'h0000, 16'h0000, 16'h0002, 16'h0000, 1, 0, 0));
        tbl.push_back(v(1, 1, 0, 1, 2'b11, 0, 1, 1, 16'h0000, 16'h0000, 16'h0003, 16'h0000, 1, 0, 0));
        // relative branches, Src1 via BRA_Src=0, upper IR bits ignored, hold beats inc
        tbl.push_back(v(1, 1, 1, 0, 2'b10, 0, 1, 1, 16'h0000, 16'h0010, 16'h0010, 16'h0000, 1, 0, 0));
        tbl.push_back(v(1, 1, 1, 0, 2'b00, 1, 1, 1, 16'h03FE, 16'h0000, 16'h000E, 16'h0000, 1, 0, 0));
        tbl.push_back(v(1, 1, 1, 0, 2'b00, 1, 1, 1, 16'h0010, 16'h0000, 16'h001E, 16'h0000, 1, 0, 0));
        tbl.push_back(v(1, 1, 1, 0, 2'b00, 0, 1, 1, 16'h0010, 16'h1234, 16'h1234, 16'h0000, 1, 0, 0));
        tbl.push_back(v(1, 1, 1, 0, 2'b00, 1, 1, 1, 16'hFC05, 16'h0000, 16'h1239, 16'h0000, 1, 0, 0));
        tbl.push_back(v(1, 1, 0, 0, 2'b11, 0, 1, 1, 16'h0000, 16'h0000, 16'h1239, 16'h0000, 1, 0, 0));
        // JPL then RET
        tbl.push_back(v(1, 1, 1, 0, 2'b10, 0, 1, 1, 16'h0000, 16'h0005, 16'h0005, 16'h0000, 1, 0, 0));
        tbl.push_back(v(1, 1, 1, 0, 2'b10, 0, 0, 1, 16'h0000, 16'h0100, 16'h0100, 16'h0005, 0, 0, 0));
        tbl.push_back(v(1, 1, 1, 0, 2'b01, 0, 1, 0, 16'h0000, 16'h0000, 16'h0005, 16'h0000, 1, 0, 0));
        // five pushes (with increment) into a depth-4 stack
        tbl.push_back(v(1, 1, 0, 1, 2'b11, 0, 0, 1, 16'h0000, 16'h0000, 16'h0006, 16'h0005, 0, 0, 0));
        tbl.push_back(v(1, 1, 0, 1, 2'b11, 0, 0, 1, 16'h0000, 16'h0000, 16'h0007, 16'h0006, 0, 0, 0));
        tbl.push_back(v(1, 1, 0, 1, 2'b11, 0, 0, 1, 16'h0000, 16'h0000, 16'h0008, 16'h0007, 0, 0, 0));
        tbl.push_back(v(1, 1, 0, 1, 2'b11, 0, 0, 1, 16'h0000, 16'h0000, 16'h0009, 16'h0008, 0, 1, 0));
        tbl.push_back(v(1, 1, 0, 1, 2'b11, 0, 0, 1, 16'h0000, 16'h0000, 16'h000A, 16'h0008, 0, 1, 1));
        // pop, replace-top, pops down to empty, underflow pop
        tbl.push_back(v(1, 1, 1, 1, 2'b11, 0, 1, 0, 16'h0000, 16'h0000, 16'h000A, 16'h0007, 0, 0, 1));
        tbl.push_back(v(1, 1, 1, 1, 2'b11, 0, 0, 0, 16'h0000, 16'h0000, 16'h000A, 16'h000A, 0, 0, 1));
        tbl.push_back(v(1, 1, 1, 1, 2'b11, 0, 1, 0, 16'h0000, 16'h0000, 16'h000A, 16'h0006, 0, 0, 1));
        tbl.push_back(v(1, 1, 1, 1, 2'b11, 0, 1, 0, 16'h0000, 16'h0000, 16'h000A, 16'h0005, 0, 0, 1));
        tbl.push_back(v(1, 1, 1, 1, 2'b11, 0, 1, 0, 16'h0000, 16'h0000, 16'h000A, 16'h0000, 1, 0, 1));
        tbl.push_back(v(1, 1, 1, 1, 2'b11, 0, 1, 0, 16'h0000, 16'h0000, 16'h000A, 16'h0000, 1, 0, 1));
        // priority: Ld over Inc, PC_Rst over Ld with stack untouched
        tbl.push_back(v(1, 1, 1, 1, 2'b11, 0, 0, 1, 16'h0000, 16'h0000, 16'h000A, 16'h000A, 0, 0, 1));
        tbl.push_back(v(1, 1, 0, 0, 2'b10, 0, 1, 1, 16'h0000, 16'h0040, 16'h0040, 16'h000A, 0, 0, 1));
        tbl.push_back(v(1, 0, 1, 0, 2'b10, 0, 1, 1, 16'h0000, 16'h0077, 16'h0000, 16'h000A, 0, 0, 1));
        // reset overrides push + load
        tbl.push_back(v(0, 1, 1, 0, 2'b10, 0, 0, 1, 16'h0000, 16'h0055, 16'h0000, 16'h0000, 1, 0, 0));
        // fresh underflow, RET on empty, push+pop on empty
        tbl.push_back(v(1, 1, 1, 1, 2'b11, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 0, 1));
        tbl.push_back(v(0, 1, 1, 1, 2'b11, 0, 1, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0));
        tbl.push_back(v(1, 1, 1, 0, 2'b10, 0, 1, 1, 16'h0000, 16'h0033, 16'h0033, 16'h0000, 1, 0, 0));
        tbl.push_back(v(1, 1, 1, 0, 2'b01, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 0, 1));
        tbl.push_back(v(0, 1, 1, 1, 2'b11, 0, 1, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0));
        tbl.push_back(v(1, 1, 1, 1, 2'b11, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 0, 1));
        tbl.push_back(v(0, 1, 1, 1, 2'b11, 0, 1, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0));
        // wrap on increment and on forward branch
        tbl.push_back(v(1, 1, 1, 0, 2'b10, 0, 1, 1, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 1, 0, 0));
        tbl.push_back(v(1, 1, 0, 1, 2'b11, 0, 1, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0));
        tbl.push_back(v(1, 1, 1, 0, 2'b10, 0, 1, 1, 16'h0000, 16'hFFFE, 16'hFFFE, 16'h0000, 1, 0, 0));
        tbl.push_back(v(1, 1, 1, 0, 2'b00, 1, 1, 1, 16'h0005, 16'h0000, 16'h0003, 16'h0000, 1, 0, 0));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

        // Level-sampled increment held low across a wrap boundary.
        step(v(1, 1, 1, 0, 2'b10, 0, 1, 1, 16'h0000, 16'hFFFC, 16'hFFFC, 16'h0000, 1, 0, 0), 100);
        pc_m = 16'hFFFC;
        for (int k = 0; k < 6; k++) begin
            pc_m = pc_m + 16'd1;
            step(v(1, 1, 0, 1, 2'b11, 0, 1, 1, 16'h0000, 16'h0000, pc_m, 16'h0000, 1, 0, 0), 101 + k);
        end

        // Push/pop round trip of distinct addresses, LIFO order.
        for (int k = 0; k < 4; k++) begin
            pc_m = 16'h0200 + 16'(k * 16);
            step(v(1, 1, 1, 0, 2'b10, 0, 1, 1, 16'h0000, pc_m, pc_m, k == 0 ? 16'h0000 : pc_m - 16'h0010,
                   k == 0, 0, 0), 110 + 2 * k);
            step(v(1, 1, 1, 1, 2'b11, 0, 0, 1, 16'h0000, 16'h0000, pc_m, pc_m, 0, k == 3, 0), 111 + 2 * k);
        end
        for (int k = 3; k >= 0; k--) begin
            pc_m = 16'h0200 + 16'(k * 16);
            step(v(1, 1, 1, 0, 2'b01, 0, 1, 0, 16'h0000, 16'h0000, pc_m,
                   k == 0 ? 16'h0000 : pc_m - 16'h0010, k == 0, 0, 0), 120 + k);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
